// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg
// Purpose  : ID/EX pipeline register for the 5-stage core. Captures decoded
//            operands, register indices and control from ID every cycle,
//            supports freeze (hold) and flush (bubble insertion), detects
//            load-use hazards combinationally and counts freeze cycles in a
//            saturating performance counter.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            freeze, flush            - hold / bubble-insert controls
//            id_*                     - decoded instruction from ID
//            ex_*                     - registered copies presented to EX
//            load_use_hazard          - ID must stall (combinational)
//            stall_count              - saturating count of freeze cycles
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CMD_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val1,
  input  logic [DATA_W-1:0] id_val2,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic              id_two_src,
  input  logic [REG_W-1:0]  id_dest,
  input  logic [CMD_W-1:0]  id_exe_cmd,
  input  logic              id_imm,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_wb_en,
  input  logic              id_branch,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [REG_W-1:0]  ex_src1,
  output logic [REG_W-1:0]  ex_src2,
  output logic [REG_W-1:0]  ex_dest,
  output logic [CMD_W-1:0]  ex_exe_cmd,
  output logic              ex_imm,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_wb_en,
  output logic              ex_branch,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Registered state
  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] pc_q,        pc_d;
  logic [DATA_W-1:0] val1_q,      val1_d;
  logic [DATA_W-1:0] val2_q,      val2_d;
  logic [REG_W-1:0]  src1_q,      src1_d;
  logic [REG_W-1:0]  src2_q,      src2_d;
  logic [REG_W-1:0]  dest_q,      dest_d;
  logic [CMD_W-1:0]  exe_cmd_q,   exe_cmd_d;
  logic              imm_q,       imm_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              wb_en_q,     wb_en_d;
  logic              branch_q,    branch_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Next-state selection: flush > freeze > load (rst handled in the flop).
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    val1_d      = val1_q;
    val2_d      = val2_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    dest_d      = dest_q;
    exe_cmd_d   = exe_cmd_q;
    imm_d       = imm_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wb_en_d     = wb_en_q;
    branch_d    = branch_q;

    if (flush) begin
      // Bubble: everything zero, even when freeze is also asserted.
      valid_d     = 1'b0;
      pc_d        = '0;
      val1_d      = '0;
      val2_d      = '0;
      src1_d      = '0;
      src2_d      = '0;
      dest_d      = '0;
      exe_cmd_d   = '0;
      imm_d       = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      wb_en_d     = 1'b0;
      branch_d    = 1'b0;
    end else if (!freeze) begin
      // Data fields are captured unconditionally; only the side-effecting
      // control bits are qualified by id_valid, so an invalid ID slot
      // becomes a bubble that never writes, stores or branches.
      valid_d     = id_valid;
      pc_d        = id_pc;
      val1_d      = id_val1;
      val2_d      = id_val2;
      src1_d      = id_src1;
      src2_d      = id_src2;
      dest_d      = id_dest;
      exe_cmd_d   = id_exe_cmd;
      imm_d       = id_imm;
      mem_read_d  = id_mem_read  & id_valid;
      mem_write_d = id_mem_write & id_valid;
      wb_en_d     = id_wb_en     & id_valid;
      branch_d    = id_branch    & id_valid;
    end
  end

  // Freeze cycles are counted even when a flush overrides the hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze && (stall_cnt_q != c_cnt_max)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      val1_q      <= '0;
      val2_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      dest_q      <= '0;
      exe_cmd_q   <= '0;
      imm_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      branch_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      dest_q      <= dest_d;
      exe_cmd_q   <= exe_cmd_d;
      imm_q       <= imm_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_en_q     <= wb_en_d;
      branch_q    <= branch_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A load in EX whose destination feeds an ID source cannot be forwarded in
  // time. Register 0 is deliberately not special-cased.
  always_comb begin
    load_use_hazard = valid_q & mem_read_q & wb_en_q & id_valid &
                      ((id_src1 == dest_q) |
                       (id_two_src & (id_src2 == dest_q)));
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_val1      = val1_q;
  assign ex_val2      = val2_q;
  assign ex_src1      = src1_q;
  assign ex_src2      = src2_q;
  assign ex_dest      = dest_q;
  assign ex_exe_cmd   = exe_cmd_q;
  assign ex_imm       = imm_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_wb_en     = wb_en_q;
  assign ex_branch    = branch_q;
  assign stall_count  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_reg
// Purpose  : Directed self-checking bench for id_ex_reg. A second instance
//            with a 3-bit stall counter shares all inputs so counter
//            saturation can be reached quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic        id_valid, id_two_src, id_imm, id_mem_read, id_mem_write, id_wb_en, id_branch;
  logic [31:0] id_pc, id_val1, id_val2;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic [3:0]  id_exe_cmd;

  logic        ex_valid, ex_imm, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, load_use_hazard;
  logic [31:0] ex_pc, ex_val1, ex_val2;
  logic [4:0]  ex_src1, ex_src2, ex_dest;
  logic [3:0]  ex_exe_cmd;
  logic [15:0] stall_count;

  logic        s_valid, s_imm, s_mem_read, s_mem_write, s_wb_en, s_branch, s_hazard;
  logic [31:0] s_pc, s_val1, s_val2;
  logic [4:0]  s_src1, s_src2, s_dest;
  logic [3:0]  s_exe_cmd;
  logic [2:0]  s_stall_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_exe_cmd(id_exe_cmd), .id_imm(id_imm), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_wb_en(id_wb_en), .id_branch(id_branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_val2(ex_val2),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest), .ex_exe_cmd(ex_exe_cmd),
    .ex_imm(ex_imm), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_wb_en(ex_wb_en), .ex_branch(ex_branch),
    .load_use_hazard(load_use_hazard), .stall_count(stall_count)
  );

  id_ex_reg #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_exe_cmd(id_exe_cmd), .id_imm(id_imm), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_wb_en(id_wb_en), .id_branch(id_branch),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_val1(s_val1), .ex_val2(s_val2),
    .ex_src1(s_src1), .ex_src2(s_src2), .ex_dest(s_dest), .ex_exe_cmd(s_exe_cmd),
    .ex_imm(s_imm), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
    .ex_wb_en(s_wb_en), .ex_branch(s_branch),
    .load_use_hazard(s_hazard), .stall_count(s_stall_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [4:0] s1, input logic [4:0] s2,
                          input logic two, input logic [4:0] d, input logic [3:0] cmd,
                          input logic imm, input logic mr, input logic mw,
                          input logic wb, input logic br);
    id_valid = v;  id_pc = pc; id_val1 = v1; id_val2 = v2;
    id_src1 = s1;  id_src2 = s2; id_two_src = two; id_dest = d;
    id_exe_cmd = cmd; id_imm = imm; id_mem_read = mr; id_mem_write = mw;
    id_wb_en = wb; id_branch = br;
  endtask

  task automatic test_reset;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    drive_id(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 1'b1,
             5'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 1'b1,
             5'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if ({ex_valid, ex_imm, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {ex_valid, ex_imm, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch});
    end
    checks++;
    if ({ex_pc, ex_val1, ex_val2, ex_src1, ex_src2, ex_dest, ex_exe_cmd} !== '0) begin
      errors++; $display("FAIL reset_data: pc=%h val1=%h val2=%h src1=%0d src2=%0d dest=%0d cmd=%h expected all 0",
        ex_pc, ex_val1, ex_val2, ex_src1, ex_src2, ex_dest, ex_exe_cmd);
    end
    checks++;
    if (stall_count !== 16'd0 || load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_haz: stall=%0d hazard=%b expected 0 0", stall_count, load_use_hazard);
    end
    rst = 1'b0;
    exp_stall = 16'd0;
  endtask

  task automatic test_load;
    drive_id(1'b1, 32'h40, 32'h1111, 32'h2222, 5'd3, 5'd7, 1'b1, 5'd5, 4'hA,
             1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_pc !== 32'h40 || ex_src1 !== 5'd3 || ex_src2 !== 5'd7 || ex_dest !== 5'd5) begin
      errors++; $display("FAIL load_fields: pc=%h src1=%0d src2=%0d dest=%0d expected 40 3 7 5",
        ex_pc, ex_src1, ex_src2, ex_dest);
    end
    checks++;
    if (ex_valid !== 1'b1 || ex_wb_en !== 1'b1 || ex_val1 !== 32'h1111 || ex_val2 !== 32'h2222 ||
        ex_exe_cmd !== 4'hA || ex_imm !== 1'b1 || ex_mem_read !== 1'b0 || ex_branch !== 1'b0) begin
      errors++; $display("FAIL load_ctrl: valid=%b wb=%b val1=%h val2=%h cmd=%h imm=%b mr=%b br=%b expected 1 1 1111 2222 a 1 0 0",
        ex_valid, ex_wb_en, ex_val1, ex_val2, ex_exe_cmd, ex_imm, ex_mem_read, ex_branch);
    end
  endtask

  task automatic test_freeze;
    freeze = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_id(1'b1, 32'h1000 + 32'(k), 32'hDEAD0000 + 32'(k), 32'hBEEF, 5'(k + 10), 5'(k + 20),
               1'b0, 5'(k), 4'(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      exp_stall = exp_stall + 16'd1;
      checks++;
      if (ex_pc !== 32'h40 || ex_src1 !== 5'd3 || ex_dest !== 5'd5 || ex_wb_en !== 1'b1 ||
          ex_mem_write !== 1'b0 || stall_count !== exp_stall) begin
        errors++; $display("FAIL freeze_hold[%0d]: pc=%h src1=%0d dest=%0d wb=%b mw=%b stall=%0d expected 40 3 5 1 0 %0d",
          k, ex_pc, ex_src1, ex_dest, ex_wb_en, ex_mem_write, stall_count, exp_stall);
      end
    end
    freeze = 1'b0;
    drive_id(1'b1, 32'h80, 32'h3, 32'h4, 5'd8, 5'd9, 1'b1, 5'd10, 4'h2,
             1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (ex_pc !== 32'h80 || ex_dest !== 5'd10 || ex_mem_write !== 1'b1 || ex_branch !== 1'b1 ||
        ex_wb_en !== 1'b0 || stall_count !== exp_stall) begin
      errors++; $display("FAIL unfreeze_load: pc=%h dest=%0d mw=%b br=%b wb=%b stall=%0d expected 80 10 1 1 0 %0d",
        ex_pc, ex_dest, ex_mem_write, ex_branch, ex_wb_en, stall_count, exp_stall);
    end
  endtask

  task automatic test_flush_freeze;
    drive_id(1'b1, 32'hC0, 32'h55, 32'h66, 5'd1, 5'd2, 1'b1, 5'd3, 4'hF,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    flush = 1'b1; freeze = 1'b1;
    tick();
    exp_stall = exp_stall + 16'd1;
    flush = 1'b0; freeze = 1'b0;
    checks++;
    if ({ex_valid, ex_imm, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch} !== 6'b0 ||
        {ex_pc, ex_val1, ex_val2, ex_src1, ex_src2, ex_dest, ex_exe_cmd} !== '0) begin
      errors++; $display("FAIL flush_bubble: valid=%b wb=%b mw=%b pc=%h val1=%h dest=%0d expected all 0",
        ex_valid, ex_wb_en, ex_mem_write, ex_pc, ex_val1, ex_dest);
    end
    checks++;
    if (stall_count !== exp_stall) begin
      errors++; $display("FAIL flush_stall_cnt: got %0d expected %0d", stall_count, exp_stall);
    end
  endtask

  task automatic test_invalid_bubble;
    drive_id(1'b0, 32'h100, 32'h77, 32'h88, 5'd6, 5'd7, 1'b1, 5'd9, 4'h3,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (ex_pc !== 32'h100 || ex_dest !== 5'd9 || ex_val1 !== 32'h77 || ex_imm !== 1'b1 ||
        {ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch} !== 5'b0) begin
      errors++; $display("FAIL invalid_bubble: pc=%h dest=%0d val1=%h imm=%b ctrl=%b expected 100 9 77 1 00000",
        ex_pc, ex_dest, ex_val1, ex_imm, {ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch});
    end
  endtask

  task automatic test_load_use;
    drive_id(1'b1, 32'h200, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd4, 4'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h204, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd6, 4'h1,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL hazard_src1: got %b expected 1", load_use_hazard);
    end
    id_src1 = 5'd0; id_src2 = 5'd4; id_two_src = 1'b0;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hazard_src2_unused: got %b expected 0", load_use_hazard);
    end
    id_two_src = 1'b1;
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL hazard_src2_used: got %b expected 1", load_use_hazard);
    end
    id_valid = 1'b0;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hazard_id_invalid: got %b expected 0", load_use_hazard);
    end
    id_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hazard_after_flush: got %b expected 0", load_use_hazard);
    end
    // Register 0 takes part in the comparison like any other index.
    drive_id(1'b1, 32'h300, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 4'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    id_src1 = 5'd0; id_mem_read = 1'b0;
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL hazard_reg0: got %b expected 1", load_use_hazard);
    end
  endtask

  task automatic test_reset_mid;
    drive_id(1'b1, 32'h400, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd4, 4'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    freeze = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; freeze = 1'b0;
    exp_stall = 16'd0;
    id_src1 = 5'd0;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0 || ex_valid !== 1'b0 || ex_dest !== 5'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid: hazard=%b valid=%b dest=%0d stall=%0d expected 0 0 0 0",
        load_use_hazard, ex_valid, ex_dest, stall_count);
    end
  endtask

  task automatic test_saturation;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    freeze = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    freeze = 1'b0;
    checks++;
    if (s_stall_count !== 3'd7) begin
      errors++; $display("FAIL sat_cnt3: got %0d expected 7", s_stall_count);
    end
    checks++;
    if (stall_count !== 16'd10) begin
      errors++; $display("FAIL cnt16_after_10: got %0d expected 10", stall_count);
    end
    tick();
    checks++;
    if (s_stall_count !== 3'd7) begin
      errors++; $display("FAIL sat_hold_no_freeze: got %0d expected 7", s_stall_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (s_stall_count !== 3'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL sat_reset: small=%0d wide=%0d expected 0 0", s_stall_count, stall_count);
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    exp_stall = 16'd0;
    drive_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 4'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_load();
    test_freeze();
    test_flush_freeze();
    test_invalid_bubble();
    test_load_use();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
